// File: rtl/adder_acc_ctrl.sv
// Beat sequencer and adder-tree accumulator between DSP-output collection and layer write-back.
// Optional macro ADDER_ACC_SAT_EN: saturate accumulator updates to signed ACC_W limits.
module adder_acc_ctrl #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned N_INPUTS = 4,
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned LEN_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [LEN_W-1:0]             cfg_len,
    output logic                         busy,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_INPUTS*DATA_W-1:0]   data_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             data_out,
    output logic                         done
);

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StDrain,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic               sum_v_q, sum_v_d;
    logic               done_q, done_d;
    logic [ACC_W-1:0]   tree_sum;
    logic [ACC_W-1:0]   acc_next;

    // Lanes are sign-extended to ACC_W before summing; the tree wraps modulo 2^ACC_W.
    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < int'(N_INPUTS); i++) begin
            tree_sum = tree_sum + ACC_W'($signed(data_in[i*DATA_W +: DATA_W]));
        end
    end

`ifdef ADDER_ACC_SAT_EN
    localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};
    logic [ACC_W:0] acc_wide;

    always_comb begin
        acc_wide = {acc_q[ACC_W-1], acc_q} + {sum_q[ACC_W-1], sum_q};
        // Top two bits disagree only on signed overflow; the extra bit gives the true sign.
        if (acc_wide[ACC_W] != acc_wide[ACC_W-1]) begin
            acc_next = acc_wide[ACC_W] ? AccMin : AccMax;
        end else begin
            acc_next = acc_wide[ACC_W-1:0];
        end
    end
`else
    always_comb begin
        acc_next = acc_q + sum_q;
    end
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        sum_v_d   = 1'b0;
        done_d    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != StIdle);

        if (sum_v_q) begin
            acc_d = acc_next;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = cfg_len;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = (cfg_len == '0) ? StDone : StAcc;
                end
            end
            StAcc: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sum_d   = tree_sum;
                    sum_v_d = 1'b1;
                    cnt_d   = cnt_q + LEN_W'(1);
                    if (cnt_d == len_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            sum_v_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            sum_v_q <= sum_v_d;
            done_q  <= done_d;
        end
    end

    assign data_out = acc_q;
    assign done     = done_q;

endmodule

// File: tb/tb_adder_acc_ctrl.sv
// Directed-vector bench for adder_acc_ctrl with N_INPUTS=4, DATA_W=8, ACC_W=16.
module tb_adder_acc_ctrl;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned N_INPUTS = 4;
    localparam int unsigned ACC_W    = 16;
    localparam int unsigned LEN_W    = 16;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        start;
    logic [LEN_W-1:0]            cfg_len;
    logic                        busy;
    logic                        in_valid;
    logic                        in_ready;
    logic [N_INPUTS*DATA_W-1:0]  data_in;
    logic                        out_valid;
    logic                        out_ready;
    logic [ACC_W-1:0]            data_out;
    logic                        done;

    int n_assert = 0;
    int n_fail   = 0;

    adder_acc_ctrl #(
        .DATA_W  (DATA_W),
        .N_INPUTS(N_INPUTS),
        .ACC_W   (ACC_W),
        .LEN_W   (LEN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_len  (cfg_len),
        .busy     (busy),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [LEN_W-1:0] len);
        start   = 1'b1;
        cfg_len = len;
        tick();
        start   = 1'b0;
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_ov_low"}, 32'(out_valid), 32'd0);
    endtask

`ifdef ADDER_ACC_SAT_EN
    localparam logic [31:0] BigExp = 32'h7FFF;
`else
    localparam logic [31:0] BigExp = 32'h5350;
`endif

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cfg_len   = '0;
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        rst = 1'b0;
        tick();

        // Single beat {1,2,3,4}
        start_run(16'd1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        data_in  = {8'd4, 8'd3, 8'd2, 8'd1};
        tick();
        in_valid = 1'b0;
        check("t1_drain_ov", 32'(out_valid), 32'd0);
        check("t1_drain_ir", 32'(in_ready), 32'd0);
        tick();
        check("t1_ov", 32'(out_valid), 32'd1);
        check("t1_data", 32'(data_out), 32'h000A);
        handshake("t1");
        check("t1_busy_idle", 32'(busy), 32'd0);
        tick();
        check("t1_done_pulse", 32'(done), 32'd0);

        // Three beats of all -1 lanes
        start_run(16'd3);
        in_valid = 1'b1;
        data_in  = 32'hFFFF_FFFF;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        check("t2_ov", 32'(out_valid), 32'd1);
        check("t2_data", 32'(data_out), 32'hFFF4);
        handshake("t2");
        tick();

        // Four beats with 2-cycle gaps, then backpressure; lanes equal beat index
        start_run(16'd4);
        for (int b = 1; b <= 4; b++) begin
            in_valid = 1'b1;
            data_in  = {4{8'(b)}};
            tick();
            in_valid = 1'b0;
            if (b < 4) begin
                check("t3_gap_ir", 32'(in_ready), 32'd1);
                tick();
                tick();
            end
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_ov", 32'(out_valid), 32'd1);
            check("t3_hold_data", 32'(data_out), 32'h0028);
            check("t3_hold_busy", 32'(busy), 32'd1);
            check("t3_hold_done", 32'(done), 32'd0);
            tick();
        end
        handshake("t3");
        tick();

        // 300 beats of 127 on every lane: wraps or saturates
        start_run(16'd300);
        in_valid = 1'b1;
        data_in  = 32'h7F7F_7F7F;
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("t4_ov", 32'(out_valid), 32'd1);
        check("t4_data", 32'(data_out), BigExp);
        handshake("t4");
        tick();

        // Reset after 2 of 5 beats, then a fresh single-beat run
        start_run(16'd5);
        in_valid = 1'b1;
        data_in  = {8'd9, 8'd9, 8'd9, 8'd9};
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_ir", 32'(in_ready), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ov", 32'(out_valid), 32'd0);
        check("t5_data", 32'(data_out), 32'd0);
        start_run(16'd1);
        in_valid = 1'b1;
        data_in  = {8'd5, 8'd5, 8'd5, 8'd5};
        tick();
        in_valid = 1'b0;
        tick();
        check("t5_new_ov", 32'(out_valid), 32'd1);
        check("t5_new_data", 32'(data_out), 32'd20);
        handshake("t5");
        tick();

        // Zero-length run; start while DONE must be ignored
        start_run(16'd0);
        check("t6_ov", 32'(out_valid), 32'd1);
        check("t6_data", 32'(data_out), 32'd0);
        start_run(16'd3);
        check("t6_ign_ov", 32'(out_valid), 32'd1);
        check("t6_ign_ir", 32'(in_ready), 32'd0);
        check("t6_ign_busy", 32'(busy), 32'd1);
        handshake("t6");

        // Back-to-back: start in the cycle done is high
        start_run(16'd1);
        check("t7_ir", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        data_in  = {8'd4, 8'd3, 8'd2, 8'd1};
        tick();
        in_valid = 1'b0;
        tick();
        check("t7_data", 32'(data_out), 32'h000A);
        handshake("t7");
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
